// File: rtl/uart_wb_ctrl.sv
// uart_wb_ctrl: Wishbone-mapped UART controller with separate TX/RX FIFOs,
// sticky clear-on-read error flags, interrupt enables and a TX launcher FSM.
// Optional feature macro: UART_WB_LOOPBACK_EN (CTRL bit3 routes TX into RX).
module uart_wb_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned TX_DEPTH   = 16,
  parameter int unsigned RX_DEPTH   = 16,
  parameter int unsigned TX_HOLDOFF = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wb_valid,
  input  logic [31:0] i_wb_adr,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_dat,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_frame_err,
  input  logic        i_tx_busy,
  output logic [7:0]  o_tx,
  output logic        o_tx_start,
  output logic        o_irq
);

  localparam int unsigned TPW = $clog2(TX_DEPTH);
  localparam int unsigned RPW = $clog2(RX_DEPTH);
  localparam int unsigned TCW = TPW + 1;
  localparam int unsigned RCW = RPW + 1;
  localparam int unsigned HCW = $clog2(TX_HOLDOFF + 1);

  localparam logic [31:0] OFF_RX    = 32'h00;
  localparam logic [31:0] OFF_TX    = 32'h04;
  localparam logic [31:0] OFF_STAT  = 32'h08;
  localparam logic [31:0] OFF_CTRL  = 32'h0C;
  localparam logic [31:0] OFF_LEVEL = 32'h10;

  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [HCW-1:0]  hold_q, hold_d;
  logic            ack_q, ack_d;
  logic [31:0]     dat_q, dat_d;
  logic [7:0]      tx_q, tx_d;
  logic            tx_start_q, tx_start_d;
  logic            irq_q, irq_d;
  logic [3:0]      ctrl_q, ctrl_d;
  logic            rxovr_q, rxovr_d, ferr_q, ferr_d, txovf_q, txovf_d;
  logic [7:0]      tx_mem_q [TX_DEPTH];
  logic [7:0]      tx_mem_d [TX_DEPTH];
  logic [TPW-1:0]  tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [TCW-1:0]  tx_cnt_q, tx_cnt_d;
  logic [7:0]      rx_mem_q [RX_DEPTH];
  logic [7:0]      rx_mem_d [RX_DEPTH];
  logic [RPW-1:0]  rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [RCW-1:0]  rx_cnt_q, rx_cnt_d;

  logic [31:0] off_c, rdata_c;
  logic        accept_c, rd_rx_c, wr_tx_c, rd_stat_c, wr_ctrl_c;
  logic        tx_empty_c, tx_full_c, rx_empty_c, rx_full_c;
  logic        launch_c, lb_c, lb_wr_c;
  logic        tx_push_c, rx_in_c, rx_push_c, rxovr_set_c, txovf_set_c;
  logic [7:0]  rx_in_dat_c;
  logic        unused_c;

`ifdef UART_WB_LOOPBACK_EN
  assign lb_c    = ctrl_q[3];
  assign lb_wr_c = i_wb_dat[3];
`else
  assign lb_c    = 1'b0;
  assign lb_wr_c = 1'b0;
`endif

  assign unused_c   = ^{i_wb_sel[3:1], i_wb_dat[31:3]};
  assign tx_empty_c = (tx_cnt_q == '0);
  assign tx_full_c  = (tx_cnt_q == TCW'(TX_DEPTH));
  assign rx_empty_c = (rx_cnt_q == '0);
  assign rx_full_c  = (rx_cnt_q == RCW'(RX_DEPTH));

  // Bus decode: one accepted request per ack, side-effect strobes
  always_comb begin
    off_c     = i_wb_adr - BASE_ADDR;
    accept_c  = i_wb_valid && !ack_q;
    rd_rx_c   = accept_c && !i_wb_we && (off_c == OFF_RX) && !rx_empty_c;
    wr_tx_c   = accept_c && i_wb_we && (off_c == OFF_TX) && i_wb_sel[0];
    rd_stat_c = accept_c && !i_wb_we && (off_c == OFF_STAT);
    wr_ctrl_c = accept_c && i_wb_we && (off_c == OFF_CTRL) && i_wb_sel[0];
  end

  // Read data mux, sampled from pre-update register state
  always_comb begin
    rdata_c = '0;
    if (off_c == OFF_RX) begin
      rdata_c = rx_empty_c ? 32'h0 : {24'h0, rx_mem_q[rx_rp_q]};
    end else if (off_c == OFF_STAT) begin
      rdata_c = {25'h0, txovf_q, ferr_q, rxovr_q, tx_full_c, tx_empty_c, rx_full_c, rx_empty_c};
    end else if (off_c == OFF_CTRL) begin
      rdata_c = {28'h0, ctrl_q};
    end else if (off_c == OFF_LEVEL) begin
      rdata_c = {16'h0, 8'(rx_cnt_q), 8'(tx_cnt_q)};
    end
  end

  // TX launcher: pop when idle and transmitter free, then hold off
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    launch_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!tx_empty_c && (!i_tx_busy || lb_c)) begin
          launch_c = 1'b1;
          hold_d   = '0;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_q == HCW'(TX_HOLDOFF - 1)) begin
          state_d = S_IDLE;
        end else begin
          hold_d = hold_q + HCW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointer/count/storage updates; a pop frees a slot for a same-cycle push
  always_comb begin
    tx_mem_d    = tx_mem_q;
    tx_wp_d     = tx_wp_q;
    tx_rp_d     = tx_rp_q;
    rx_mem_d    = rx_mem_q;
    rx_wp_d     = rx_wp_q;
    rx_rp_d     = rx_rp_q;
    tx_push_c   = wr_tx_c && (!tx_full_c || launch_c);
    txovf_set_c = wr_tx_c && tx_full_c && !launch_c;
    rx_in_c     = lb_c ? launch_c : (i_rx_valid && !i_frame_err);
    rx_in_dat_c = lb_c ? tx_mem_q[tx_rp_q] : i_rx_data;
    rx_push_c   = rx_in_c && (!rx_full_c || rd_rx_c);
    rxovr_set_c = rx_in_c && rx_full_c && !rd_rx_c;
    if (tx_push_c) begin
      tx_mem_d[tx_wp_q] = i_wb_dat[7:0];
      tx_wp_d           = tx_wp_q + TPW'(1);
    end
    if (launch_c) tx_rp_d = tx_rp_q + TPW'(1);
    if (rx_push_c) begin
      rx_mem_d[rx_wp_q] = rx_in_dat_c;
      rx_wp_d           = rx_wp_q + RPW'(1);
    end
    if (rd_rx_c) rx_rp_d = rx_rp_q + RPW'(1);
    tx_cnt_d = tx_cnt_q + TCW'(tx_push_c) - TCW'(launch_c);
    rx_cnt_d = rx_cnt_q + RCW'(rx_push_c) - RCW'(rd_rx_c);
  end

  // Control, sticky flags (set beats read-clear), bus and serial outputs
  always_comb begin
    ctrl_d     = ctrl_q;
    if (wr_ctrl_c) ctrl_d = {lb_wr_c, i_wb_dat[2:0]};
    rxovr_d    = (rxovr_q & ~rd_stat_c) | rxovr_set_c;
    ferr_d     = (ferr_q & ~rd_stat_c) | i_frame_err;
    txovf_d    = (txovf_q & ~rd_stat_c) | txovf_set_c;
    ack_d      = accept_c;
    dat_d      = (accept_c && !i_wb_we) ? rdata_c : 32'h0;
    tx_start_d = launch_c && !lb_c;
    tx_d       = tx_start_d ? tx_mem_q[tx_rp_q] : tx_q;
    irq_d      = (ctrl_q[0] & !rx_empty_c) | (ctrl_q[1] & tx_empty_c) |
                 (ctrl_q[2] & (rxovr_q | ferr_q | txovf_q));
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hold_q     <= '0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      tx_q       <= '0;
      tx_start_q <= 1'b0;
      irq_q      <= 1'b0;
      ctrl_q     <= '0;
      rxovr_q    <= 1'b0;
      ferr_q     <= 1'b0;
      txovf_q    <= 1'b0;
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      tx_cnt_q   <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      rx_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      tx_q       <= tx_d;
      tx_start_q <= tx_start_d;
      irq_q      <= irq_d;
      ctrl_q     <= ctrl_d;
      rxovr_q    <= rxovr_d;
      ferr_q     <= ferr_d;
      txovf_q    <= txovf_d;
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      rx_cnt_q   <= rx_cnt_d;
    end
  end

  // FIFO storage; contents are don't-care while the count is zero
  always_ff @(posedge clk) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
  end

  assign o_wb_ack   = ack_q;
  assign o_wb_dat   = dat_q;
  assign o_tx       = tx_q;
  assign o_tx_start = tx_start_q;
  assign o_irq      = irq_q;

endmodule

// File: tb/tb_uart_wb_ctrl.sv
// Self-checking bench for uart_wb_ctrl: register vector table, directed
// multi-cycle sequences and a randomized run against a queue-based model.
module tb_uart_wb_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_wb_valid, i_wb_we;
  logic [31:0] i_wb_adr, i_wb_dat;
  logic [3:0]  i_wb_sel;
  logic        o_wb_ack;
  logic [31:0] o_wb_dat;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid, i_frame_err, i_tx_busy;
  logic [7:0]  o_tx;
  logic        o_tx_start, o_irq;

  uart_wb_ctrl dut (
    .clk(clk), .rst(rst),
    .i_wb_valid(i_wb_valid), .i_wb_adr(i_wb_adr), .i_wb_we(i_wb_we),
    .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel),
    .o_wb_ack(o_wb_ack), .o_wb_dat(o_wb_dat),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .i_frame_err(i_frame_err),
    .i_tx_busy(i_tx_busy), .o_tx(o_tx), .o_tx_start(o_tx_start), .o_irq(o_irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  logic [7:0] seen_b[$];
  int         seen_c[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Launch monitor: records each o_tx_start pulse with its cycle stamp
  always @(negedge clk) begin
    if (o_tx_start) begin
      seen_b.push_back(o_tx);
      seen_c.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // One bus transfer; optional RX strobe in the request cycle. Entry/exit at #1 after posedge.
  task automatic bus(input logic we, input logic [31:0] off, input logic [31:0] dat,
                     input logic [3:0] sel, input logic rxv, input logic [7:0] rxd,
                     input logic fe, output logic [31:0] rd);
    i_wb_valid = 1'b1; i_wb_adr = BASE + off; i_wb_we = we; i_wb_dat = dat; i_wb_sel = sel;
    i_rx_valid = rxv; i_rx_data = rxd; i_frame_err = fe;
    @(posedge clk); #1;
    last_acc = cyc;
    i_wb_valid = 1'b0; i_wb_we = 1'b0; i_rx_valid = 1'b0; i_frame_err = 1'b0;
    chk("ack", {31'h0, o_wb_ack}, 32'h1);
    rd = o_wb_dat;
    @(posedge clk); #1;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] rd;
    bus(1'b0, off, 32'h0, 4'h1, 1'b0, 8'h0, 1'b0, rd);
    chk(nm, rd, exp);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] dat);
    logic [31:0] rd;
    bus(1'b1, off, dat, 4'h1, 1'b0, 8'h0, 1'b0, rd);
  endtask

  task automatic rx_strobe(input logic [7:0] d, input logic fe);
    i_rx_valid = 1'b1; i_rx_data = d; i_frame_err = fe;
    @(posedge clk); #1;
    i_rx_valid = 1'b0; i_frame_err = 1'b0;
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int k = 0;
    while (seen_b.size() < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk("pulse_count", 32'(seen_b.size()), 32'(n));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] off;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        cmp;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t vt[20];

  // Behavioural model state for the randomized run
  logic [7:0] mq_tx[$];
  logic [7:0] mq_rx[$];
  logic       m_rxovr, m_ferr, m_txovf;
  logic [2:0] m_ctrl;

  initial begin
    logic [31:0] rd, exp, dat;
    logic [7:0]  rxd, pb;
    logic        rxv, fe, popping, s_rxovr, s_txovf, we, exp_irq;
    logic [3:0]  sel;
    logic [31:0] off;
    int          op, c0, base_n;

    vt[0]  = '{1'b0, 32'h08, 32'h0,  4'h1, 1'b1, 32'h05, "stat_reset"};
    vt[1]  = '{1'b0, 32'h10, 32'h0,  4'h1, 1'b1, 32'h00, "level_reset"};
    vt[2]  = '{1'b0, 32'h0C, 32'h0,  4'h1, 1'b1, 32'h00, "ctrl_reset"};
    vt[3]  = '{1'b1, 32'h0C, 32'h7,  4'h1, 1'b0, 32'h00, "ctrl_wr7"};
    vt[4]  = '{1'b0, 32'h0C, 32'h0,  4'h1, 1'b1, 32'h07, "ctrl_rd7"};
    vt[5]  = '{1'b1, 32'h0C, 32'h0,  4'h0, 1'b0, 32'h00, "ctrl_wr_nosel"};
    vt[6]  = '{1'b0, 32'h0C, 32'h0,  4'h1, 1'b1, 32'h07, "ctrl_nosel_kept"};
    vt[7]  = '{1'b1, 32'h0C, 32'hF,  4'h1, 1'b0, 32'h00, "ctrl_wrF"};
`ifdef UART_WB_LOOPBACK_EN
    vt[8]  = '{1'b0, 32'h0C, 32'h0,  4'h1, 1'b1, 32'h0F, "ctrl_rdF"};
`else
    vt[8]  = '{1'b0, 32'h0C, 32'h0,  4'h1, 1'b1, 32'h07, "ctrl_rdF"};
`endif
    vt[9]  = '{1'b1, 32'h0C, 32'h0,  4'h1, 1'b0, 32'h00, "ctrl_wr0"};
    vt[10] = '{1'b0, 32'h04, 32'h0,  4'h1, 1'b1, 32'h00, "txdata_read"};
    vt[11] = '{1'b0, 32'h00, 32'h0,  4'h1, 1'b1, 32'h00, "rxdata_empty"};
    vt[12] = '{1'b1, 32'h04, 32'h99, 4'h0, 1'b0, 32'h00, "tx_nosel"};
    vt[13] = '{1'b0, 32'h10, 32'h0,  4'h1, 1'b1, 32'h00, "level_nosel"};
    vt[14] = '{1'b0, 32'h20, 32'h0,  4'h1, 1'b1, 32'h00, "unmapped_rd"};
    vt[15] = '{1'b0, 32'hFFFF_FFF8, 32'h0, 4'h1, 1'b1, 32'h00, "below_base_rd"};
    vt[16] = '{1'b1, 32'h08, 32'hFF, 4'h1, 1'b0, 32'h00, "stat_wr"};
    vt[17] = '{1'b1, 32'h00, 32'h55, 4'h1, 1'b0, 32'h00, "rxdata_wr"};
    vt[18] = '{1'b0, 32'h08, 32'h0,  4'h1, 1'b1, 32'h05, "stat_after_wr"};
    vt[19] = '{1'b0, 32'h10, 32'h0,  4'h1, 1'b1, 32'h00, "level_after_wr"};

    i_wb_valid = 0; i_wb_adr = 0; i_wb_we = 0; i_wb_dat = 0; i_wb_sel = 0;
    i_rx_data = 0; i_rx_valid = 0; i_frame_err = 0; i_tx_busy = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ack", {31'h0, o_wb_ack}, 32'h0);
    chk("rst_dat", o_wb_dat, 32'h0);
    chk("rst_tx", {24'h0, o_tx}, 32'h0);
    chk("rst_txstart", {31'h0, o_tx_start}, 32'h0);
    chk("rst_irq", {31'h0, o_irq}, 32'h0);

    for (int i = 0; i < 20; i++) begin
      bus(vt[i].we, vt[i].off, vt[i].dat, vt[i].sel, 1'b0, 8'h0, 1'b0, rd);
      if (vt[i].cmp) chk(vt[i].nm, rd, vt[i].exp);
    end

    // Two launches: latency and holdoff spacing
    seen_b.delete(); seen_c.delete();
    wr(32'h04, 32'h41);
    c0 = last_acc;
    wr(32'h04, 32'h42);
    wait_pulses(2, 40);
    if (seen_b.size() >= 2) begin
      chk("tx_lat", 32'(seen_c[0]), 32'(c0 + 1));
      chk("tx_b0", {24'h0, seen_b[0]}, 32'h41);
      chk("tx_b1", {24'h0, seen_b[1]}, 32'h42);
      chk("tx_gap", {31'h0, seen_c[1] - seen_c[0] >= 3}, 32'h1);
    end
    repeat (4) @(posedge clk); #1;
    rd_chk("stat_tx_drained", 32'h08, 32'h05);

    // TX overflow and clear-on-read of TXOVF
    i_tx_busy = 1'b1;
    for (int i = 0; i < 17; i++) wr(32'h04, 32'h60 + 32'(i));
    rd_chk("level_txfull", 32'h10, 32'h0010);
    rd_chk("stat_txovf", 32'h08, 32'h49);
    rd_chk("stat_txovf_clr", 32'h08, 32'h09);
    seen_b.delete(); seen_c.delete();
    i_tx_busy = 1'b0;
    wait_pulses(16, 200);
    for (int i = 0; i < 16; i++)
      if (i < seen_b.size()) chk("tx_drain_byte", {24'h0, seen_b[i]}, 32'h60 + 32'(i));
    repeat (5) @(posedge clk); #1;
    rd_chk("stat_tx_empty", 32'h08, 32'h05);

    // RX overrun, ordered reads, read on empty
    for (int i = 0; i <= 16; i++) rx_strobe(8'(i), 1'b0);
    rd_chk("stat_rxovr", 32'h08, 32'h16);
    rd_chk("level_rxfull", 32'h10, 32'h1000);
    for (int i = 0; i < 16; i++) rd_chk("rx_byte", 32'h00, 32'(i));
    rd_chk("rx_empty_read", 32'h00, 32'h0);
    rd_chk("stat_rx_clean", 32'h08, 32'h05);

    // RX interrupt rises one cycle after push, falls after the read
    wr(32'h0C, 32'h1);
    rx_strobe(8'h77, 1'b0);
    chk("irq_lag", {31'h0, o_irq}, 32'h0);
    @(posedge clk); #1;
    chk("irq_rise", {31'h0, o_irq}, 32'h1);
    rd_chk("irq_rx_byte", 32'h00, 32'h77);
    chk("irq_fall", {31'h0, o_irq}, 32'h0);

    // Pop and push on a full RX FIFO: no overrun
    for (int i = 0; i < 16; i++) rx_strobe(8'h80 + 8'(i), 1'b0);
    bus(1'b0, 32'h00, 32'h0, 4'h1, 1'b1, 8'hA5, 1'b0, rd);
    chk("full_pop", rd, 32'h80);
    rd_chk("stat_no_rxovr", 32'h08, 32'h06);
    wr(32'h0C, 32'h0);
    for (int i = 1; i < 16; i++) rd_chk("full_pop_seq", 32'h00, 32'h80 + 32'(i));
    rd_chk("full_pop_new", 32'h00, 32'hA5);

    // Frame error discards byte; set wins over same-cycle clear
    rx_strobe(8'h33, 1'b1);
    rd_chk("ferr_level", 32'h10, 32'h0);
    rd_chk("ferr_stat", 32'h08, 32'h25);
    bus(1'b0, 32'h08, 32'h0, 4'h1, 1'b0, 8'h0, 1'b1, rd);
    chk("ferr_pre_clear", rd, 32'h05);
    rd_chk("ferr_set_wins", 32'h08, 32'h25);
    rd_chk("ferr_cleared", 32'h08, 32'h05);

    // Reset mid-operation drops FIFOs and the pending ack
    i_tx_busy = 1'b1;
    wr(32'h04, 32'h11); wr(32'h04, 32'h12);
    rx_strobe(8'h21, 1'b0);
    i_wb_valid = 1'b1; i_wb_adr = BASE + 32'h08; i_wb_we = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_drop_ack", {31'h0, o_wb_ack}, 32'h0);
    i_wb_valid = 1'b0; rst = 1'b0;
    seen_b.delete(); seen_c.delete();
    i_tx_busy = 1'b0;
    rd_chk("rst_mid_level", 32'h10, 32'h0);
    rd_chk("rst_mid_stat", 32'h08, 32'h05);
    repeat (6) @(posedge clk); #1;
    chk("rst_mid_no_tx", 32'(seen_b.size()), 32'h0);

`ifdef UART_WB_LOOPBACK_EN
    // Loopback: TX byte lands in RX FIFO without a launch pulse
    seen_b.delete(); seen_c.delete();
    wr(32'h0C, 32'h8);
    wr(32'h04, 32'h5A);
    repeat (10) @(posedge clk); #1;
    chk("lb_no_start", 32'(seen_b.size()), 32'h0);
    rd_chk("lb_rx", 32'h00, 32'h5A);
    wr(32'h0C, 32'h0);
`endif

    // Randomized register traffic against the queue model
    do_reset();
    i_tx_busy = 1'b1;
    mq_tx.delete(); mq_rx.delete();
    m_rxovr = 0; m_ferr = 0; m_txovf = 0; m_ctrl = 0;
    for (int it = 0; it < 300; it++) begin
      op  = int'($urandom_range(0, 5));
      rxv = 1'($urandom_range(0, 1));
      fe  = ($urandom_range(0, 9) == 0);
      rxd = 8'($urandom);
      dat = $urandom;
      sel = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'h1;
      we  = (op == 1 || op == 4);
      case (op)
        0: off = 32'h00;
        1: off = 32'h04;
        2: off = 32'h08;
        3: off = 32'h10;
        default: off = 32'h0C;
      endcase
      if (op == 4) dat = dat & 32'h7;
      exp = 32'h0;
      case (op)
        2: exp = {25'h0, m_txovf, m_ferr, m_rxovr, mq_tx.size() == 16,
                  mq_tx.size() == 0, mq_rx.size() == 16, mq_rx.size() == 0};
        3: exp = {16'h0, 8'(mq_rx.size()), 8'(mq_tx.size())};
        5: exp = {29'h0, m_ctrl};
        default: exp = 32'h0;
      endcase
      popping = (op == 0) && (mq_rx.size() > 0);
      s_rxovr = 1'b0;
      s_txovf = 1'b0;
      if (popping) begin
        pb  = mq_rx.pop_front();
        exp = {24'h0, pb};
      end
      if (rxv && !fe) begin
        if (mq_rx.size() < 16) mq_rx.push_back(rxd);
        else s_rxovr = 1'b1;
      end
      if (op == 1 && sel[0]) begin
        if (mq_tx.size() < 16) mq_tx.push_back(dat[7:0]);
        else s_txovf = 1'b1;
      end
      if (op == 4 && sel[0]) m_ctrl = dat[2:0];
      if (op == 2) begin
        m_rxovr = 0; m_ferr = 0; m_txovf = 0;
      end
      m_rxovr = m_rxovr | s_rxovr;
      m_ferr  = m_ferr | fe;
      m_txovf = m_txovf | s_txovf;
      bus(we, off, dat, sel, rxv, rxd, fe, rd);
      if (!we) chk("rand_rd", rd, exp);
      exp_irq = (m_ctrl[0] && mq_rx.size() > 0) || (m_ctrl[1] && mq_tx.size() == 0) ||
                (m_ctrl[2] && (m_rxovr || m_ferr || m_txovf));
      chk("rand_irq", {31'h0, o_irq}, {31'h0, exp_irq});
    end
    seen_b.delete(); seen_c.delete();
    base_n = mq_tx.size();
    i_tx_busy = 1'b0;
    wait_pulses(base_n, 200);
    for (int i = 0; i < base_n; i++)
      if (i < seen_b.size()) chk("rand_tx_order", {24'h0, seen_b[i]}, {24'h0, mq_tx[i]});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_wb_ctrl.md
# uart_wb_ctrl

Parametrised Wishbone-mapped UART controller; successor to the single-TX-FIFO UART control block. Sits between the Wishbone slave decode and the UART TX/RX serial engines. It provides separate TX and RX FIFOs of configurable depth and sticky error flags that are cleared on read. It also has a control register with interrupt enables and a combined registered interrupt output.

## Interface
- BASE_ADDR, 32'h3000_0000, base address; register offsets below are relative to it
- TX_DEPTH, 16, TX FIFO entries (power of 2, ≥2)
- RX_DEPTH, 16, RX FIFO entries (power of 2, ≥2)
- TX_HOLDOFF, 2, idle cycles after each o_tx_start pulse before the next pop is allowed (≥1)
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_wb_valid  in  1  bus request
- i_wb_adr  in  32  byte address
- i_wb_we  in  1  1 = write
- i_wb_dat  in  32  write data
- i_wb_sel  in  4  byte enables; only bit 0 is honoured for TX_DATA and CTRL
- o_wb_ack  out  1  one-cycle acknowledge
- o_wb_dat  out  32  read data, valid with o_wb_ack
- i_rx_data  in  8  byte from the receiver
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid
- i_frame_err  in  1  one-cycle strobe from the receiver
- i_tx_busy  in  1  transmitter shifting
- o_tx  out  8  byte to the transmitter
- o_tx_start  out  1  one-cycle launch pulse
- o_irq  out  1  level interrupt

## Operation
- Register map (offsets from BASE_ADDR):
  - 0x00 RX_DATA (R): pops the RX FIFO and returns {24'b0, byte}; returns 0 with no pop when the FIFO is empty. Writes are ignored.
  - 0x04 TX_DATA (W): pushes i_wb_dat[7:0] when i_wb_sel[0] is set. A push into a full FIFO is dropped and sets TXOVF. Reads return 0.
  - 0x08 STAT (R): bit0 rx_empty, bit1 rx_full, bit2 tx_empty, bit3 tx_full, bit4 RXOVR, bit5 FERR, bit6 TXOVF. A read clears bits 4–6. Writes are ignored.
  - 0x0C CTRL (R/W): bit0 rx_ie, bit1 txe_ie, bit2 err_ie, bit3 loopback (see Configuration).
  - 0x10 LEVEL (R): [15:8] RX count, [7:0] TX count.
  - Any other address: ack with data 0, no side effect.
- Bus handshake:
  - A request is accepted when i_wb_valid && !o_wb_ack.
  - An accepted request gets exactly one ack pulse.
  - Back-to-back requests therefore complete at most every 2 cycles.
- RX path:
  - i_rx_valid && !i_frame_err pushes i_rx_data.
  - If the RX FIFO is full and no pop occurs that cycle, the byte is dropped and RXOVR is set.
  - i_frame_err sets FERR; a byte strobed in the same cycle is discarded.
- TX launcher FSM:
  - IDLE: when the TX FIFO is non-empty and !i_tx_busy, pop the FIFO, drive o_tx, pulse o_tx_start for 1 cycle, then go to HOLD.
  - HOLD: count TX_HOLDOFF cycles, then return to IDLE.
  - o_tx holds its value until the next launch.
- Interrupt: o_irq is registered from (rx_ie & !rx_empty) | (txe_ie & tx_empty) | (err_ie & (RXOVR|FERR|TXOVF)).

## Timing
- Reset values:
  - o_wb_ack=0, o_wb_dat=0, o_tx=0, o_tx_start=0, o_irq=0
  - CTRL=0, both FIFOs empty, all sticky flags 0, FSM in IDLE
  - STAT therefore reads 0x05.
- Reset mid-operation empties both FIFOs and drops any pending ack.
- Bus latency: request accepted in cycle N → o_wb_ack and o_wb_dat in cycle N+1. FIFO pop/push and sticky clear take effect at the N→N+1 edge.
- TX latency: a push accepted at edge E with an idle launcher → o_tx_start high in the cycle after E+1, i.e. 2 cycles after the write is accepted.
- Simultaneous push and pop on the same FIFO:
  - Both take effect; count is unchanged.
  - On a full FIFO, the push succeeds and no overflow is flagged.
- Sticky set and STAT-read clear in the same cycle: set wins, so the flag reads 1 next time.
- STAT read data reflects flags before the clear.
- o_irq lags its condition by 1 cycle.
- Counts are log2(DEPTH)+1 bits, zero-extended into 8-bit LEVEL fields. Pointers wrap modulo DEPTH.

## Configuration
- UART_WB_LOOPBACK_EN defined: CTRL bit3 is writable.
  - When it is set, the launcher pops TX bytes straight into the RX FIFO. Normal overrun rules apply.
  - o_tx_start stays 0, and i_rx_valid is ignored.
- Undefined: CTRL bit3 reads 0, writes to it are ignored, and the loopback logic is absent.

## Test plan
- Reset → STAT reads 0x05, LEVEL reads 0, o_irq=0.
- Write 0x41, 0x42 to TX_DATA with i_tx_busy=0 → two o_tx_start pulses with o_tx=0x41 then 0x42, at least TX_HOLDOFF+1 cycles apart; STAT bit2 returns to 1.
- Write TX_DEPTH+1 bytes with i_tx_busy=1 → LEVEL[7:0]=16 and STAT bit3=1; a STAT read returns bit6=1, and a second read returns bit6=0.
- Strobe RX_DEPTH+1 bytes 0x00..0x10 → RXOVR set; 16 RX_DATA reads return 0x00..0x0F; a 17th read returns 0.
- CTRL=0x1, then one RX byte → o_irq rises 1 cycle after the push and falls after the RX_DATA read. A read of RX_DATA while i_rx_valid strobes on a full FIFO → no RXOVR.
- With the macro defined: CTRL=0x8, write 0x5A → o_tx_start never pulses and RX_DATA reads 0x5A.
